// File: rtl/text_pkg.sv
// Shared constants for the 80x30 text-mode display: cell geometry,
// VRAM sizing and the palette field layout of ctrl_color.
package text_pkg;
   localparam int unsigned CHAR_W = 8;
   localparam int unsigned CHAR_H = 16;
   localparam int unsigned COLS   = 80;
   localparam int unsigned ROWS   = 30;
   localparam int unsigned WORDS  = COLS * ROWS / 4;

   localparam int unsigned FG_R_HI = 24;
   localparam int unsigned FG_R_LO = 21;
   localparam int unsigned FG_G_HI = 20;
   localparam int unsigned FG_G_LO = 17;
   localparam int unsigned FG_B_HI = 16;
   localparam int unsigned FG_B_LO = 13;
   localparam int unsigned BG_R_HI = 12;
   localparam int unsigned BG_R_LO = 9;
   localparam int unsigned BG_G_HI = 8;
   localparam int unsigned BG_G_LO = 5;
   localparam int unsigned BG_B_HI = 4;
   localparam int unsigned BG_B_LO = 1;

   localparam int unsigned INV_BIT = 7;
endpackage

// File: rtl/text_vram_fetch_blink_timer.sv
// Cursor blink generator: counts frame-start pulses and toggles
// blink_phase every BLINK_FRAMES frames.
module blink_timer #(
   parameter int unsigned BLINK_FRAMES = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_start,
   output logic blink_phase
);
   logic [7:0] frame_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (frame_start) begin
         if (frame_cnt == 8'(BLINK_FRAMES - 1)) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end
endmodule

// File: rtl/text_vram_fetch.sv
// Pixel-side text VRAM reader: raster position -> VRAM word address,
// byte select, cursor inversion and palette shadow, 2-cycle aligned.
module text_vram_fetch
   import text_pkg::*;
#(
   parameter int unsigned COLS         = text_pkg::COLS,
   parameter int unsigned ROWS         = text_pkg::ROWS,
   parameter int unsigned BLINK_FRAMES = 30,
   parameter int unsigned ADDR_W       = 10
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              vde_in,
   input  logic              hs_in,
   input  logic              vs_in,
   input  logic [31:0]       ctrl_color,
   input  logic              cursor_en,
   input  logic [6:0]        cursor_col,
   input  logic [4:0]        cursor_row,
   output logic [ADDR_W-1:0] vram_addr,
   input  logic [31:0]       vram_rdata,
   output logic [7:0]        draw_code,
   output logic [31:0]       draw_sig,
   output logic [9:0]        DrawX_out,
   output logic [9:0]        DrawY_out,
   output logic              vde_out,
   output logic              hs_out,
   output logic              vs_out
);
   logic [6:0]  col;
   logic [5:0]  row;
   logic [11:0] idx;
   logic        frame_start;
   logic        blink_phase;
   logic        cursor_hit;
   logic        cursor_legal;

   logic [1:0]  s1_sel;
   logic        s1_hit, s1_vde, s1_hs, s1_vs;
   logic [9:0]  s1_x, s1_y;
   logic [31:0] shadow;
   logic [7:0]  sel_byte;

   always_comb begin
      col          = DrawX[9:3];
      row          = DrawY[9:4];
      idx          = 12'(row) * 12'(COLS) + 12'(col);
      frame_start  = (DrawX == '0) && (DrawY == '0);
      cursor_legal = (32'(cursor_col) < COLS) && (32'(cursor_row) < ROWS);
      cursor_hit   = cursor_en & blink_phase & cursor_legal &
                     (col == cursor_col) & (row == {1'b0, cursor_row});
      sel_byte     = vram_rdata[{s1_sel, 3'b000} +: 8];
   end

   blink_timer #(
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_blink (
      .clk         (Clk),
      .reset       (Reset),
      .frame_start (frame_start),
      .blink_phase (blink_phase)
   );

   // Stage 0: address issue; vram_rdata for this address is valid next cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vram_addr <= '0;
         s1_sel    <= '0;
         s1_hit    <= 1'b0;
         s1_vde    <= 1'b0;
         s1_hs     <= 1'b0;
         s1_vs     <= 1'b0;
         s1_x      <= '0;
         s1_y      <= '0;
         shadow    <= '0;
      end else begin
         if (vde_in)
            vram_addr <= ADDR_W'(idx >> 2);
         s1_sel <= idx[1:0];
         s1_hit <= cursor_hit;
         s1_vde <= vde_in;
         s1_hs  <= hs_in;
         s1_vs  <= vs_in;
         s1_x   <= DrawX;
         s1_y   <= DrawY;
         if (frame_start)
            shadow <= ctrl_color;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         draw_code <= '0;
         draw_sig  <= '0;
         DrawX_out <= '0;
         DrawY_out <= '0;
         vde_out   <= 1'b0;
         hs_out    <= 1'b0;
         vs_out    <= 1'b0;
      end else begin
         if (s1_vde) begin
            draw_code          <= sel_byte;
            draw_code[INV_BIT] <= sel_byte[INV_BIT] ^ s1_hit;
         end else begin
            draw_code <= '0;
         end
         draw_sig  <= shadow;
         DrawX_out <= s1_x;
         DrawY_out <= s1_y;
         vde_out   <= s1_vde;
         hs_out    <= s1_hs;
         vs_out    <= s1_vs;
      end
   end
endmodule

// File: tb/tb_text_vram_fetch.sv
// Directed bench for text_vram_fetch with a scoreboard of expected outputs.
module tb_text_vram_fetch;
   localparam int unsigned BF = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        vde_in, hs_in, vs_in;
   logic [31:0] ctrl_color;
   logic        cursor_en;
   logic [6:0]  cursor_col;
   logic [4:0]  cursor_row;
   logic [9:0]  vram_addr;
   logic [31:0] vram_rdata;
   logic [7:0]  draw_code;
   logic [31:0] draw_sig;
   logic [9:0]  DrawX_out, DrawY_out;
   logic        vde_out, hs_out, vs_out;

   logic [31:0] mem [0:1023];

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0]  code;
      logic [31:0] sig;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        vde;
      logic        hs;
      logic        vs;
   } exp_t;

   exp_t sb[$];

   int          mcnt;
   logic        mphase;
   logic [31:0] mshadow;
   logic [9:0]  maddr;

   always #5 Clk = ~Clk;

   assign vram_rdata = mem[vram_addr];

   text_vram_fetch #(
      .COLS         (80),
      .ROWS         (30),
      .BLINK_FRAMES (BF),
      .ADDR_W       (10)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .vde_in     (vde_in),
      .hs_in      (hs_in),
      .vs_in      (vs_in),
      .ctrl_color (ctrl_color),
      .cursor_en  (cursor_en),
      .cursor_col (cursor_col),
      .cursor_row (cursor_row),
      .vram_addr  (vram_addr),
      .vram_rdata (vram_rdata),
      .draw_code  (draw_code),
      .draw_sig   (draw_sig),
      .DrawX_out  (DrawX_out),
      .DrawY_out  (DrawY_out),
      .vde_out    (vde_out),
      .hs_out     (hs_out),
      .vs_out     (vs_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic step(input logic [9:0] x, input logic [9:0] y, input logic vde, input logic rst);
      exp_t e;
      int   c, r, idx;
      logic hit;
      logic [31:0] w;
      logic [7:0]  b;
      DrawX  = x;
      DrawY  = y;
      vde_in = vde;
      hs_in  = x[0];
      vs_in  = y[0];
      Reset  = rst;
      e = '{code: 8'h00, sig: 32'h0, x: 10'h0, y: 10'h0, vde: 1'b0, hs: 1'b0, vs: 1'b0};
      if (rst) begin
         sb.delete();
         mcnt = 0; mphase = 1'b0; mshadow = '0; maddr = '0;
      end else begin
         c = int'(x) / 8;
         r = int'(y) / 16;
         idx = r * 80 + c;
         hit = cursor_en && mphase && (c == int'(cursor_col)) && (r == int'(cursor_row))
               && (int'(cursor_col) < 80) && (int'(cursor_row) < 30);
         if (vde) begin
            maddr = 10'(idx / 4);
            w = mem[idx / 4];
            b = 8'(w >> (8 * (idx % 4)));
            e.code = hit ? (b ^ 8'h80) : b;
         end
         if (x == 0 && y == 0) begin
            mshadow = ctrl_color;
            if (mcnt == BF - 1) begin
               mcnt = 0;
               mphase = ~mphase;
            end else begin
               mcnt++;
            end
         end
         e.sig = mshadow;
         e.x = x; e.y = y; e.vde = vde; e.hs = x[0]; e.vs = y[0];
      end
      sb.push_back(e);
      @(posedge Clk);
      #1;
      chk("vram_addr", {22'h0, vram_addr}, {22'h0, maddr});
      if (rst) begin
         chk("reset_outs", {draw_code, vde_out, hs_out, vs_out, DrawX_out, DrawY_out},
             32'h0);
         chk("reset_sig", draw_sig, 32'h0);
      end else if (sb.size() >= 2) begin
         e = sb.pop_front();
         chk("draw_code", {24'h0, draw_code}, {24'h0, e.code});
         chk("draw_sig", draw_sig, e.sig);
         chk("xy_out", {12'h0, DrawX_out, DrawY_out}, {12'h0, e.x, e.y});
         chk("sync_out", {29'h0, vde_out, hs_out, vs_out}, {29'h0, e.vde, e.hs, e.vs});
      end
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) step(10'd700, 10'd520, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h9E3779B9 * (i + 1);
      mem[0]   = 32'h44434241;
      mem[599] = 32'h55AA3311;
      mem[41]  = 32'h00004100;
      mem[60]  = 32'h00000081;
      mem[62]  = 32'h41414141;
      ctrl_color = 32'h00ABC000;
      cursor_en  = 1'b0;
      cursor_col = 7'd0;
      cursor_row = 5'd0;

      for (int i = 0; i < 3; i++) step(10'd100, 10'd50, 1'b1, 1'b1);
      blank(2);
      for (int i = 0; i < 4; i++) step(10'(100 + i), 10'd50, 1'b1, 1'b0);
      blank(2);

      step(10'd0, 10'd0, 1'b1, 1'b0);
      for (int x = 1; x < 32; x++) step(10'(x), 10'd0, 1'b1, 1'b0);
      blank(3);

      step(10'd632, 10'd479, 1'b1, 1'b0);
      blank(3);

      ctrl_color = 32'h01FFE000;
      for (int x = 0; x < 8; x++) step(10'(x), 10'd200, 1'b1, 1'b0);
      blank(2);
      step(10'd0, 10'd0, 1'b1, 1'b0);
      for (int x = 1; x < 4; x++) step(10'(x), 10'd0, 1'b1, 1'b0);
      blank(2);

      cursor_en  = 1'b1;
      cursor_col = 7'd5;
      cursor_row = 5'd2;
      for (int f = 0; f < 5; f++) begin
         step(10'd0, 10'd0, 1'b1, 1'b0);
         for (int x = 38; x < 50; x++) step(10'(x), 10'd32, 1'b1, 1'b0);
         for (int x = 40; x < 48; x++) step(10'(x), 10'd47, 1'b1, 1'b0);
         blank(2);
      end

      cursor_col = 7'd0;
      cursor_row = 5'd3;
      for (int f = 0; f < 2; f++) begin
         step(10'd0, 10'd0, 1'b1, 1'b0);
         for (int x = 0; x < 10; x++) step(10'(x), 10'd48, 1'b1, 1'b0);
         blank(2);
      end

      cursor_col = 7'd90;
      cursor_row = 5'd2;
      for (int f = 0; f < 4; f++) begin
         step(10'd0, 10'd0, 1'b1, 1'b0);
         for (int x = 40; x < 48; x++) step(10'(x), 10'd32, 1'b1, 1'b0);
         for (int x = 720; x < 728; x++) step(10'(x), 10'd32, 1'b1, 1'b0);
         blank(2);
      end

      step(10'd300, 10'd100, 1'b1, 1'b0);
      step(10'd301, 10'd100, 1'b1, 1'b0);
      step(10'd302, 10'd100, 1'b1, 1'b1);
      step(10'd303, 10'd100, 1'b1, 1'b1);
      for (int x = 304; x < 308; x++) step(10'(x), 10'd100, 1'b1, 1'b0);
      blank(2);
      step(10'd0, 10'd0, 1'b1, 1'b0);
      for (int x = 1; x < 4; x++) step(10'(x), 10'd0, 1'b1, 1'b0);
      blank(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
